ifid_pipe_reg: RTL
==================

// Module: ifid_pipe_reg
// PURPOSE
//  Parametrised IF/ID pipeline register for the 5-stage MIPS core with valid/ready handshake.
//  Captures fetched instruction, PC and PC+4; presents pre-decoded fields to ID.
//  A 2-entry skid buffer (main M + skid S) sustains 1 instr/cycle under hazard stalls.
//  Supports flush for taken branches and jumps.
// PARAMETERS
//  PC_W       32     width of PC and PC+4 paths
//  NOP_INSTR  32'h0  instruction word loaded into M on reset/flush (sll $0,$0,0)
//  CNT_W      16     width of performance counters (IFID_PERF_EN only)
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      asynchronous, active-high reset
//  in_valid    in   1      IF presents a fetched instruction
//  in_ready    out  1      register can accept; registered, equals !S_valid
//  in_instr    in   32     fetched instruction word
//  in_pc       in   PC_W   PC of the instruction
//  in_pc4      in   PC_W   PC+4
//  flush       in   1      discard all held instructions (branch/jump taken)
//  out_valid   out  1      M holds a valid instruction for ID
//  out_ready   in   1      ID consumes; 0 = hazard stall
//  out_instr   out  32     M instruction word
//  out_pc      out  PC_W   M PC
//  out_pc4     out  PC_W   M PC+4
//  out_opcode  out  6      instr[31:26]
//  out_rs      out  5      instr[25:21]
//  out_rt      out  5      instr[20:16]
//  out_rd      out  5      instr[15:11]
//  out_shamt   out  5      instr[10:6]
//  out_funct   out  6      instr[5:0]
//  out_imm     out  16     instr[15:0]
//  out_target  out  26     instr[25:0]
//  stall_cnt   out  CNT_W  cycles with out_valid & !out_ready
//  flush_cnt   out  CNT_W  cycles with flush asserted
// BEHAVIOUR
//  - Reset: M_valid=S_valid=0, out_valid=0, in_ready=1, out_instr=NOP_INSTR, out_pc=out_pc4=0,
//    fields = decode of NOP_INSTR, counters=0.
//  - acc = in_valid & in_ready; drn = out_valid & out_ready. Decode fields are combinational from M.
//  - Priority per edge: flush > (drn | !M_valid) > acc into S.
//  - flush: M_valid=S_valid=0, M data=NOP_INSTR/pc 0; same-cycle acc is dropped; in_ready=1 next cycle.
//  - M empty or draining: M <= S if S_valid (S_valid<=0); else M <= in if acc; else M_valid<=0.
//  - M full, not draining, acc: S <= in, S_valid<=1 (in_ready falls next cycle).
//  - S_valid=1 implies in_ready=0: no accept while S occupied, so S never overwritten.
//  - Latency in->out 1 cycle when empty; throughput 1/cycle; strict program order.
//  - rst asserted mid-stall clears both entries immediately (async); no instruction survives.
//  - out_* data holds its last value while out_valid=0 (except after reset/flush: NOP).
// CONFIGURATION
//  IFID_PERF_EN defined: stall_cnt/flush_cnt count as above, saturating at 2^CNT_W-1, reset to 0.
//  IFID_PERF_EN undefined: ports remain, tied to 0; no counter flops inferred.
// TESTING
//  1. rst=1 then release -> out_valid=0, in_ready=1, out_instr=0, out_opcode=0.
//  2. in_instr=32'h8C220004, pc=0x100, out_ready=1 -> next cycle out_valid=1, opcode=0x23,
//     rs=1, rt=2, imm=0x0004, target=0x0220004, pc4=0x104.
//  3. Stream A,B,C; out_ready=0 after A lands -> B in S, in_ready=0, C held upstream;
//     out_ready=1 -> A,B,C delivered in order, no loss or duplicate, stall_cnt=stall cycles.
//  4. M and S full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1,
//     out_instr=NOP_INSTR, new instr not captured; flush_cnt=1.
//  5. rst pulsed asynchronously mid-stall with S full -> outputs to reset values immediately.
//  6. Without IFID_PERF_EN, rerun test 3 -> stall_cnt=flush_cnt=0; with CNT_W=2, hold stall 5
//     cycles -> stall_cnt saturates at 3.

Source files
------------

// File: rtl/ifid_pipe_reg.sv
// IF/ID pipeline register: two-entry (main + skid) buffer with valid/ready handshake, flush and MIPS field pre-decode.
// Optional stall/flush performance counters are built only when IFID_PERF_EN is defined.
module ifid_pipe_reg #(
  parameter int          PC_W      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  input  logic [PC_W-1:0]  in_pc4,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [PC_W-1:0]  out_pc,
  output logic [PC_W-1:0]  out_pc4,
  output logic [5:0]       out_opcode,
  output logic [4:0]       out_rs,
  output logic [4:0]       out_rt,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_shamt,
  output logic [5:0]       out_funct,
  output logic [15:0]      out_imm,
  output logic [25:0]      out_target,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic            m_valid;
  logic            s_valid;
  logic [31:0]     m_instr;
  logic [31:0]     s_instr;
  logic [PC_W-1:0] m_pc;
  logic [PC_W-1:0] m_pc4;
  logic [PC_W-1:0] s_pc;
  logic [PC_W-1:0] s_pc4;
  logic            acc;
  logic            drn;
  logic            load_m;

  // in_ready comes straight from a flop, so IF never sees a combinational path from ID's ready.
  assign in_ready  = ~s_valid;
  assign out_valid = m_valid;
  assign acc       = in_valid & in_ready;
  assign drn       = m_valid & out_ready;
  assign load_m    = drn | ~m_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (load_m) begin
      if (s_valid) begin
        m_valid <= 1'b1;
        s_valid <= 1'b0;
      end else begin
        m_valid <= acc;
      end
    end else if (acc) begin
      s_valid <= 1'b1;
    end
  end

  // Main entry data holds its last value when nothing new is loaded; reset/flush park a NOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_instr <= NOP_INSTR;
      m_pc    <= '0;
      m_pc4   <= '0;
    end else if (flush) begin
      m_instr <= NOP_INSTR;
      m_pc    <= '0;
      m_pc4   <= '0;
    end else if (load_m) begin
      if (s_valid) begin
        m_instr <= s_instr;
        m_pc    <= s_pc;
        m_pc4   <= s_pc4;
      end else if (acc) begin
        m_instr <= in_instr;
        m_pc    <= in_pc;
        m_pc4   <= in_pc4;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_instr <= '0;
      s_pc    <= '0;
      s_pc4   <= '0;
    end else if (!flush && !load_m && acc) begin
      s_instr <= in_instr;
      s_pc    <= in_pc;
      s_pc4   <= in_pc4;
    end
  end

  assign out_instr  = m_instr;
  assign out_pc     = m_pc;
  assign out_pc4    = m_pc4;
  assign out_opcode = m_instr[31:26];
  assign out_rs     = m_instr[25:21];
  assign out_rt     = m_instr[20:16];
  assign out_rd     = m_instr[15:11];
  assign out_shamt  = m_instr[10:6];
  assign out_funct  = m_instr[5:0];
  assign out_imm    = m_instr[15:0];
  assign out_target = m_instr[25:0];

`ifdef IFID_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  // Both counters saturate rather than wrap so a long run never reports a small value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (m_valid && !out_ready && stall_q != CNT_MAX) begin
        stall_q <= stall_q + 1'b1;
      end
      if (flush && flush_q != CNT_MAX) begin
        flush_q <= flush_q + 1'b1;
      end
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
